// File: rtl/opb_register_ppc2simulink_sc.sv
// OPB slave control register (PPC -> fabric): byte-enabled writes, ack one cycle after select, update strobe one cycle later.
// Define OPB_PPC2SL_READBACK_EN to return the register on reads; otherwise reads are acked with zero data.
module opb_register_ppc2simulink_sc #(
   parameter logic [31:0] C_BASEADDR    = 32'h01008A00,
   parameter logic [31:0] C_HIGHADDR    = 32'h01008AFF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter              C_FAMILY      = "virtex5",
   parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic [31:0]             user_data_out,
   output logic                    user_data_valid
);

   typedef enum logic [1:0] {IDLE, ACK, RECOVER} state_t;

   localparam logic [31:0] addr_mask = ~(C_HIGHADDR - C_BASEADDR);

   state_t                  state;
   logic [0:3]              be_q;
   logic [0:C_OPB_DWIDTH-1] dbus_q;
   logic                    rnw_q;
   logic                    hit;

   // Burst hints and the family string have no effect on a single register.
   wire unused_ok = &{1'b0, OPB_seqAddr, C_FAMILY[0]};

   assign hit        = (OPB_ABus & addr_mask) == C_BASEADDR;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state           <= IDLE;
         be_q            <= '0;
         dbus_q          <= '0;
         rnw_q           <= 1'b0;
         Sl_xferAck      <= 1'b0;
         Sl_DBus         <= '0;
         user_data_out   <= C_RESET_VALUE;
         user_data_valid <= 1'b0;
      end else begin
         Sl_xferAck      <= 1'b0;
         Sl_DBus         <= '0;
         user_data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (OPB_select && hit) begin
                  be_q       <= OPB_BE;
                  dbus_q     <= OPB_DBus;
                  rnw_q      <= OPB_RNW;
                  Sl_xferAck <= 1'b1;
`ifdef OPB_PPC2SL_READBACK_EN
                  if (OPB_RNW)
                     Sl_DBus <= user_data_out;
`endif
                  state      <= ACK;
               end
            end
            ACK: begin
               // A master that drops select during the ack cycle has aborted.
               if (OPB_select && !rnw_q) begin
                  for (int k = 0; k < 4; k++)
                     if (be_q[k])
                        user_data_out[31-8*k -: 8] <= dbus_q[8*k +: 8];
                  user_data_valid <= |be_q;
               end
               state <= RECOVER;
            end
            RECOVER: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
